alu_wb_slice: RTL and testbench

Execute-stage slice of the 4-bit single-cycle CPU. A 4-bit registered ALU produces the result and the Zero/Carry flags, a 4-bit write-back mux selects ALU result or memory read data, and a 2-bit mux selects the second register-read address. The CPU top instantiates one copy for the main datapath. Address adders (PC+1, PC+imm) use the same ALU core with op ADD.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 69 ++++++
 rtl/alu_wb_slice.sv | 77 +++++++
 tb/tb_alu_wb_slice.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU slice: widths, opcodes,
// reset values and a small flag helper.
// Optional feature macro: ALU_MULDIV_EN (enables MUL and DIV opcodes).
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int RADDR_W = 2;
    localparam int OP_W    = 4;

    // Opcodes 7..15 are undefined and produce a zero result with no carry.
    typedef enum logic [OP_W-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_SUB = 4'd5,
        OP_NOR = 4'd6
    } alu_op_e;

    // Register values after reset: a zero result, so the zero flag is set.
    localparam logic [DATA_W-1:0] RESULT_RST = '0;
    localparam logic              ZERO_RST   = 1'b1;
    localparam logic              CARRY_RST  = 1'b0;

    // Saturated quotient reported on divide-by-zero.
    localparam logic [DATA_W-1:0] DIV0_RESULT = '1;

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: decodes the opcode into the next result and carry.
// Reused by the PC adders with op ADD, so it holds no state.
// Optional feature macro: ALU_MULDIV_EN (adds multiplier and divider).
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    // Arithmetic is computed one bit wider so the top bit is carry/borrow.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

`ifdef ALU_MULDIV_EN
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   quot;

    assign prod    = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    // Keep the divider away from a zero divisor; that case is overridden below.
    assign divisor = (b_i == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b_i;
    assign quot    = a_i / divisor;
`endif

    // Opcode decode; undefined opcodes fall to the zero default.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                result_o = prod[DATA_W-1:0];
                carry_o  = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (b_i == '0) begin
                    result_o = DIV0_RESULT;
                    carry_o  = 1'b1;
                end else begin
                    result_o = quot;
                end
            end
`endif
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_NOR: result_o = ~(a_i | b_i);
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_wb_slice.sv
// Execute-stage slice: registered ALU result/flags, write-back mux and
// second register-read address mux. The muxes are purely combinational.
// Optional feature macro: ALU_MULDIV_EN (forwarded to alu_core).
module alu_wb_slice
    import alu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                carry,
    input  logic [DATA_W-1:0]   read_data,
    input  logic                mem_to_reg,
    output logic [DATA_W-1:0]   wb_data,
    input  logic [RADDR_W-1:0]  addr_ry,
    input  logic [RADDR_W-1:0]  addr_rz,
    input  logic                reg2loc,
    output logic [RADDR_W-1:0]  read_addr2
);

    logic [DATA_W-1:0] result_d;
    logic              carry_d;
    logic              zero_d;

    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              zero_q;

    alu_core u_alu_core (
        .op_i     (alu_op),
        .a_i      (a),
        .b_i      (b),
        .result_o (result_d),
        .carry_o  (carry_d)
    );

    // Zero flag tracks the next result for every opcode, undefined ones too.
    always_comb begin
        zero_d = is_zero(result_d);
    end

    // Result and flag registers; reset wins over any op in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= RESULT_RST;
            zero_q   <= ZERO_RST;
            carry_q  <= CARRY_RST;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;

    // Write-back mux follows the registered result with zero latency.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_wb_mux
            assign wb_data[gi] = mem_to_reg ? read_data[gi] : result_q[gi];
        end
    endgenerate

    // Second read-port address select between the Ry and Rz fields.
    generate
        for (gi = 0; gi < RADDR_W; gi++) begin : g_raddr_mux
            assign read_addr2[gi] = reg2loc ? addr_rz[gi] : addr_ry[gi];
        end
    endgenerate

endmodule

// File: tb/tb_alu_wb_slice.sv
// Self-checking bench for alu_wb_slice: directed steps followed by random
// operations compared against an arithmetic reference model.
module tb_alu_wb_slice;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] a, b, alu_op;
    logic [3:0] result;
    logic       zero, carry;
    logic [3:0] read_data;
    logic       mem_to_reg;
    logic [3:0] wb_data;
    logic [1:0] addr_ry, addr_rz;
    logic       reg2loc;
    logic [1:0] read_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected registered state according to the reference model.
    logic [3:0] exp_res;
    logic       exp_z, exp_c;

    always #5 clock = ~clock;

    alu_wb_slice dut (
        .clock      (clock),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .read_data  (read_data),
        .mem_to_reg (mem_to_reg),
        .wb_data    (wb_data),
        .addr_ry    (addr_ry),
        .addr_rz    (addr_rz),
        .reg2loc    (reg2loc),
        .read_addr2 (read_addr2)
    );

    // Reference ALU from the opcode table; returns {carry, result}.
    function automatic logic [4:0] ref_alu(input int op, input int x, input int y);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0: r = x & y;
            1: r = x | y;
            2: begin r = (x + y) % 16; c = (x + y > 15) ? 1 : 0; end
`ifdef ALU_MULDIV_EN
            3: begin r = (x * y) % 16; c = (x * y > 15) ? 1 : 0; end
            4: begin
                if (y == 0) begin r = 15; c = 1; end
                else r = x / y;
            end
`endif
            5: begin r = (x - y + 16) % 16; c = (x < y) ? 1 : 0; end
            6: r = 15 - (x | y);
            default: begin r = 0; c = 0; end
        endcase
        return {c[0], r[3:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clocked transaction: drive, clock, update model, check outputs.
    task automatic cycle(input logic rst, input int op, input int x, input int y,
                         input logic mtr, input logic [3:0] rd,
                         input logic r2l, input logic [1:0] ry, input logic [1:0] rz,
                         input string tag);
        logic [4:0] m;
        reset      = rst;
        alu_op     = op[3:0];
        a          = x[3:0];
        b          = y[3:0];
        mem_to_reg = mtr;
        read_data  = rd;
        reg2loc    = r2l;
        addr_ry    = ry;
        addr_rz    = rz;
        @(posedge clock);
        if (rst) begin
            exp_res = 4'd0; exp_z = 1'b1; exp_c = 1'b0;
        end else begin
            m       = ref_alu(op, x, y);
            exp_res = m[3:0];
            exp_c   = m[4];
            exp_z   = (m[3:0] == 4'd0);
        end
        #1;
        $display("%s: rst=%0b op=%0d a=%0d b=%0d -> result=%0d zero=%0b carry=%0b wb=%0d ra2=%0d",
                 tag, rst, op, x, y, result, zero, carry, wb_data, read_addr2);
        check({tag, " result"}, {4'd0, result}, {4'd0, exp_res});
        check({tag, " zero"},   {7'd0, zero},   {7'd0, exp_z});
        check({tag, " carry"},  {7'd0, carry},  {7'd0, exp_c});
        check({tag, " wb_data"}, {4'd0, wb_data}, {4'd0, (mtr ? rd : exp_res)});
        check({tag, " read_addr2"}, {6'd0, read_addr2}, {6'd0, (r2l ? rz : ry)});
    endtask

    task automatic expect_rzc(input string tag, input logic [3:0] r, input logic z, input logic c);
        check({tag, " lit result"}, {4'd0, result}, {4'd0, r});
        check({tag, " lit zero"},   {7'd0, zero},   {7'd0, z});
        check({tag, " lit carry"},  {7'd0, carry},  {7'd0, c});
    endtask

    initial begin
        // Reset overrides ADD 3+4; release gives 7.
        cycle(1'b1, 2, 3, 4, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "reset");
        expect_rzc("reset", 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 2, 3, 4, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "add3+4");
        expect_rzc("add3+4", 4'd7, 1'b0, 1'b0);

        // ADD overflow then no overflow.
        cycle(1'b0, 2, 9, 8, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "add9+8");
        expect_rzc("add9+8", 4'd1, 1'b0, 1'b1);
        cycle(1'b0, 2, 1, 1, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "add1+1");
        expect_rzc("add1+1", 4'd2, 1'b0, 1'b0);

        // SUB equal operands sets zero; borrow wraps to 15.
        cycle(1'b0, 5, 4, 4, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "sub4-4");
        expect_rzc("sub4-4", 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 5, 0, 1, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "sub0-1");
        expect_rzc("sub0-1", 4'd15, 1'b0, 1'b1);

        // MUL/DIV, including divide-by-zero.
        cycle(1'b0, 3, 4, 4, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "mul4*4");
`ifdef ALU_MULDIV_EN
        expect_rzc("mul4*4", 4'd0, 1'b1, 1'b1);
`else
        expect_rzc("mul4*4", 4'd0, 1'b1, 1'b0);
`endif
        cycle(1'b0, 4, 9, 2, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "div9/2");
`ifdef ALU_MULDIV_EN
        expect_rzc("div9/2", 4'd4, 1'b0, 1'b0);
`else
        expect_rzc("div9/2", 4'd0, 1'b1, 1'b0);
`endif
        cycle(1'b0, 4, 9, 0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "div9/0");
`ifdef ALU_MULDIV_EN
        expect_rzc("div9/0", 4'd15, 1'b0, 1'b1);
`else
        expect_rzc("div9/0", 4'd0, 1'b1, 1'b0);
`endif

        // Logic ops and an undefined op.
        cycle(1'b0, 0, 5, 3, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "and");
        expect_rzc("and", 4'b0001, 1'b0, 1'b0);
        cycle(1'b0, 1, 5, 3, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "or");
        expect_rzc("or", 4'b0111, 1'b0, 1'b0);
        cycle(1'b0, 6, 5, 3, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "nor");
        expect_rzc("nor", 4'b1000, 1'b0, 1'b0);
        cycle(1'b0, 9, 5, 3, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, "op9");
        expect_rzc("op9", 4'd0, 1'b1, 1'b0);

        // Muxes: result = 6, then toggle selects between clock edges.
        cycle(1'b0, 2, 3, 3, 1'b0, 4'hA, 1'b0, 2'd1, 2'd3, "add3+3");
        mem_to_reg = 1'b0; #1;
        check("wb sel result", {4'd0, wb_data}, 8'h06);
        mem_to_reg = 1'b1; #1;
        check("wb sel mem", {4'd0, wb_data}, 8'h0A);
        reg2loc = 1'b0; #1;
        check("ra2 sel ry", {6'd0, read_addr2}, 8'd1);
        reg2loc = 1'b1; #1;
        check("ra2 sel rz", {6'd0, read_addr2}, 8'd3);

        // Random operations with occasional resets.
        for (int i = 0; i < 300; i++) begin
            int op;
            logic rst;
            op  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 15));
            rst = ($urandom_range(0, 15) == 0);
            cycle(rst, op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
